// File: rtl/fault_input_filter.sv
// fault_input_filter: per-channel synchronizer, asymmetric debounce and chatter
// detection for raw fault lines ahead of the fault-latch inputs.
module fault_input_filter #(
  parameter int unsigned N_CH            = 8,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned ASSERT_CYCLES   = 16,
  parameter int unsigned DEASSERT_CYCLES = 64,
  parameter int unsigned CHATTER_LIMIT   = 4,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  input  logic            bypass,
  input  logic            chatter_clr,
  output logic [N_CH-1:0] filt_out,
  output logic [N_CH-1:0] filt_rise,
  output logic [N_CH-1:0] chatter_flag,
  output logic            any_chatter
);

  localparam logic [CNT_W-1:0] ASSERT_C   = CNT_W'(ASSERT_CYCLES);
  localparam logic [CNT_W-1:0] DEASSERT_C = CNT_W'(DEASSERT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       LIMIT_C    = 4'(CHATTER_LIMIT);
  localparam logic             POL        = 1'(ACTIVE_LOW);
  // Single-sample thresholds skip the qualification states entirely.
  localparam logic             ASSERT_ONE   = (ASSERT_CYCLES == 1);
  localparam logic             DEASSERT_ONE = (DEASSERT_CYCLES == 1);

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_QUAL_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_QUAL_LO = 2'd3
  } state_t;

  logic [N_CH-1:0] x;
  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] flag_nxt;

  // Normalise polarity so everything downstream is active-high.
  assign x = raw_in ^ {N_CH{POL}};

  // Two-flop synchronizer; reset value is the inactive level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= x;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       ab_cnt;
    logic [3:0]       ab_nxt;
    logic             hi_c;
    logic             abort_c;
    logic             out_c;
    logic             flg_nxt;
    logic             fo;
    logic             fr;
    logic             flag;

    assign cnt_inc = cnt + CNT_ONE;

    // Decode of the filtered level after this edge and of aborted qualifications.
    always_comb begin
      hi_c    = 1'b0;
      abort_c = 1'b0;
      case (state)
        ST_LOW: begin
          hi_c = s2[i] & ASSERT_ONE;
        end
        ST_QUAL_HI: begin
          hi_c    = s2[i] & (cnt_inc == ASSERT_C);
          abort_c = ~s2[i];
        end
        ST_HIGH: begin
          hi_c = s2[i] | ~DEASSERT_ONE;
        end
        ST_QUAL_LO: begin
          hi_c    = s2[i] | (cnt_inc != DEASSERT_C);
          abort_c = s2[i];
        end
        default: begin
          hi_c    = 1'b0;
          abort_c = 1'b0;
        end
      endcase
    end

    // Debounce FSM; the compare against the threshold ends qualification before cnt can wrap.
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= ST_LOW;
        cnt   <= '0;
      end else begin
        case (state)
          ST_LOW: begin
            if (s2[i]) begin
              if (ASSERT_ONE) begin
                state <= ST_HIGH;
                cnt   <= '0;
              end else begin
                state <= ST_QUAL_HI;
                cnt   <= CNT_ONE;
              end
            end
          end
          ST_QUAL_HI: begin
            if (s2[i]) begin
              if (cnt_inc == ASSERT_C) begin
                state <= ST_HIGH;
                cnt   <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= ST_LOW;
              cnt   <= '0;
            end
          end
          ST_HIGH: begin
            if (!s2[i]) begin
              if (DEASSERT_ONE) begin
                state <= ST_LOW;
                cnt   <= '0;
              end else begin
                state <= ST_QUAL_LO;
                cnt   <= CNT_ONE;
              end
            end
          end
          ST_QUAL_LO: begin
            if (!s2[i]) begin
              if (cnt_inc == DEASSERT_C) begin
                state <= ST_LOW;
                cnt   <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= ST_HIGH;
              cnt   <= '0;
            end
          end
          default: begin
            state <= ST_LOW;
            cnt   <= '0;
          end
        endcase
      end
    end

    // Bypass shows the synchronized line; the FSM keeps tracking underneath.
    assign out_c = bypass ? s2[i] : hi_c;

    // Registered filtered level and its rising-edge pulse.
    always_ff @(posedge clk) begin
      if (reset) begin
        fo <= 1'b0;
        fr <= 1'b0;
      end else begin
        fo <= out_c;
        fr <= out_c & ~fo;
      end
    end

    // Next abort count and sticky flag; a clear overrides a simultaneous abort.
    always_comb begin
      ab_nxt  = ab_cnt;
      flg_nxt = flag;
      if (chatter_clr) begin
        ab_nxt  = 4'd0;
        flg_nxt = 1'b0;
      end else if (abort_c) begin
        if (ab_cnt != 4'hF) begin
          ab_nxt = ab_cnt + 4'd1;
        end
        flg_nxt = flag | (ab_nxt >= LIMIT_C);
      end
    end

    // Chatter counter and flag registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        ab_cnt <= 4'd0;
        flag   <= 1'b0;
      end else begin
        ab_cnt <= ab_nxt;
        flag   <= flg_nxt;
      end
    end

    assign filt_out[i]     = fo;
    assign filt_rise[i]    = fr;
    assign chatter_flag[i] = flag;
    assign flag_nxt[i]     = flg_nxt;
  end : g_ch

  // Registered OR of the flags, aligned with chatter_flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      any_chatter <= 1'b0;
    end else begin
      any_chatter <= |flag_nxt;
    end
  end

endmodule

// File: tb/tb_fault_input_filter.sv
// Scoreboard bench for fault_input_filter: three parameterisations, a run-length
// reference model, directed scenarios followed by randomized traffic.
module tb_fault_input_filter;

  typedef struct packed {
    logic [7:0] fo;
    logic [7:0] fr;
    logic [7:0] cf;
    logic       any;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, bypass, chatter_clr;
  logic [7:0] raw0, raw1;
  logic [7:0] fo0, fr0, cf0, fo1, fr1, cf1, fo2, fr2, cf2;
  logic       any0, any1, any2;

  fault_input_filter #(.N_CH(8), .CNT_W(8), .ASSERT_CYCLES(16), .DEASSERT_CYCLES(64),
                       .CHATTER_LIMIT(4), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .reset(reset), .raw_in(raw0), .bypass(bypass), .chatter_clr(chatter_clr),
    .filt_out(fo0), .filt_rise(fr0), .chatter_flag(cf0), .any_chatter(any0));

  fault_input_filter #(.N_CH(8), .CNT_W(8), .ASSERT_CYCLES(16), .DEASSERT_CYCLES(64),
                       .CHATTER_LIMIT(4), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .reset(reset), .raw_in(raw1), .bypass(bypass), .chatter_clr(chatter_clr),
    .filt_out(fo1), .filt_rise(fr1), .chatter_flag(cf1), .any_chatter(any1));

  fault_input_filter #(.N_CH(8), .CNT_W(8), .ASSERT_CYCLES(3), .DEASSERT_CYCLES(1),
                       .CHATTER_LIMIT(2), .ACTIVE_LOW(0)) dut2 (
    .clk(clk), .reset(reset), .raw_in(raw0), .bypass(bypass), .chatter_clr(chatter_clr),
    .filt_out(fo2), .filt_rise(fr2), .chatter_flag(cf2), .any_chatter(any2));

  int n_chk = 0;
  int n_err = 0;

  int P_A[3]  = '{16, 16, 3};
  int P_D[3]  = '{64, 64, 1};
  int P_L[3]  = '{4, 4, 2};
  bit P_AL[3] = '{1'b0, 1'b1, 1'b0};

  // Reference model: delay line plus run length of samples disagreeing with the level.
  bit m_s1[3][8], m_s2[3][8], m_lvl[3][8], m_fo[3][8], m_fr[3][8], m_flag[3][8];
  int m_run[3][8], m_ab[3][8];

  obs_t [2:0] exp_q[$];

  function void model_step(input int i, input logic [7:0] raw);
    for (int c = 0; c < 8; c++) begin
      if (reset) begin
        m_s1[i][c] = 0; m_s2[i][c] = 0; m_lvl[i][c] = 0; m_fo[i][c] = 0;
        m_fr[i][c] = 0; m_flag[i][c] = 0; m_run[i][c] = 0; m_ab[i][c] = 0;
      end else begin
        bit samp, ab, nfo;
        int thr;
        samp = m_s2[i][c];
        ab = 0;
        if (samp != m_lvl[i][c]) begin
          m_run[i][c]++;
          thr = m_lvl[i][c] ? P_D[i] : P_A[i];
          if (m_run[i][c] == thr) begin
            m_lvl[i][c] = samp;
            m_run[i][c] = 0;
          end
        end else begin
          if (m_run[i][c] > 0) ab = 1;
          m_run[i][c] = 0;
        end
        nfo = bypass ? samp : m_lvl[i][c];
        m_fr[i][c] = nfo & ~m_fo[i][c];
        m_fo[i][c] = nfo;
        if (chatter_clr) begin
          m_ab[i][c] = 0;
          m_flag[i][c] = 0;
        end else if (ab) begin
          if (m_ab[i][c] < 15) m_ab[i][c]++;
          if (m_ab[i][c] >= P_L[i]) m_flag[i][c] = 1;
        end
        m_s2[i][c] = m_s1[i][c];
        m_s1[i][c] = raw[c] ^ P_AL[i];
      end
    end
  endfunction

  function obs_t model_obs(input int i);
    obs_t o;
    o = '0;
    for (int c = 0; c < 8; c++) begin
      o.fo[c] = m_fo[i][c];
      o.fr[c] = m_fr[i][c];
      o.cf[c] = m_flag[i][c];
      o.any   = o.any | m_flag[i][c];
    end
    return o;
  endfunction

  task automatic cmp8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  // Predict the effect of the coming edge, then advance to the following negedge.
  task automatic tick();
    obs_t [2:0] e;
    model_step(0, raw0);
    model_step(1, raw1);
    model_step(2, raw0);
    e[0] = model_obs(0);
    e[1] = model_obs(1);
    e[2] = model_obs(2);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per edge and compares all outputs.
  initial begin
    obs_t [2:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp8("i0_filt_out", fo0, e[0].fo);
        cmp8("i0_filt_rise", fr0, e[0].fr);
        cmp8("i0_chatter_flag", cf0, e[0].cf);
        cmp8("i0_any_chatter", {7'd0, any0}, {7'd0, e[0].any});
        cmp8("i1_filt_out", fo1, e[1].fo);
        cmp8("i1_filt_rise", fr1, e[1].fr);
        cmp8("i1_chatter_flag", cf1, e[1].cf);
        cmp8("i1_any_chatter", {7'd0, any1}, {7'd0, e[1].any});
        cmp8("i2_filt_out", fo2, e[2].fo);
        cmp8("i2_filt_rise", fr2, e[2].fr);
        cmp8("i2_chatter_flag", cf2, e[2].cf);
        cmp8("i2_any_chatter", {7'd0, any2}, {7'd0, e[2].any});
      end
    end
  end

  task automatic glitch(input int ch, input int hi, input int lo, input int clr_at);
    for (int k = 0; k < hi + lo; k++) begin
      raw0[ch]    = (k < hi);
      chatter_clr = (k == clr_at);
      tick();
    end
    chatter_clr = 1'b0;
  endtask

  initial begin
    int first;
    int ones;
    reset = 1'b1; bypass = 1'b0; chatter_clr = 1'b0;
    raw0 = 8'hFF; raw1 = 8'hFF;

    // Reset with all lines active, then assert latency on channel 0.
    repeat (3) tick();
    dchk("reset_filt_out", {24'd0, fo0}, 0);
    dchk("reset_any_chatter", {31'd0, any0}, 0);
    reset = 1'b0;
    first = -1;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (first < 0 && fo0[0] === 1'b1) first = e;
    end
    dchk("assert_latency_ch0", first, 17);
    raw0 = 8'h01;
    repeat (80) tick();

    // Short glitches on channel 2 build up chatter.
    for (int g = 0; g < 4; g++) begin
      glitch(2, 10, 20, -1);
      dchk("glitch_filt_out_ch2", {31'd0, fo0[2]}, 0);
      dchk("glitch_flag_ch2", {31'd0, cf0[2]}, (g == 3) ? 1 : 0);
    end
    dchk("glitch_any_chatter", {31'd0, any0}, 1);

    // Channel 3: aborted deassert, then a full deassert.
    raw0[3] = 1'b1; repeat (30) tick();
    dchk("ch3_asserted", {31'd0, fo0[3]}, 1);
    raw0[3] = 1'b0; repeat (40) tick();
    raw0[3] = 1'b1; repeat (10) tick();
    dchk("ch3_held_through_dip", {31'd0, fo0[3]}, 1);
    raw0[3] = 1'b0;
    first = -1;
    for (int e = 0; e < 80; e++) begin
      tick();
      if (first < 0 && fo0[3] === 1'b0) first = e;
    end
    dchk("deassert_latency_ch3", first, 65);

    // Clear colliding with an abort, then re-accumulate.
    glitch(2, 10, 20, 12);
    dchk("clr_wins_flag_ch2", {31'd0, cf0[2]}, 0);
    for (int g = 0; g < 4; g++) begin
      glitch(2, 10, 20, -1);
      dchk("reaccum_flag_ch2", {31'd0, cf0[2]}, (g == 3) ? 1 : 0);
    end

    // Bypass passes a one-cycle pulse through.
    bypass = 1'b1;
    repeat (5) tick();
    raw0[5] = 1'b1;
    first = -1; ones = 0;
    for (int e = 0; e < 8; e++) begin
      if (e == 1) raw0[5] = 1'b0;
      tick();
      if (fo0[5] === 1'b1) begin
        ones++;
        if (first < 0) first = e;
      end
    end
    dchk("bypass_pulse_delay", first, 2);
    dchk("bypass_pulse_width", ones, 1);
    bypass = 1'b0;
    repeat (3) tick();
    dchk("bypass_off_ch5", {31'd0, fo0[5]}, 0);

    // Active-low instance: idle high reads inactive, low asserts.
    dchk("al_idle", {24'd0, fo1}, 0);
    raw1[7] = 1'b0; repeat (20) tick();
    dchk("al_assert_ch7", {31'd0, fo1[7]}, 1);
    raw1[7] = 1'b1;
    raw1[1] = 1'b0; repeat (8) tick();
    reset = 1'b1; repeat (2) tick();
    reset = 1'b0;
    first = -1;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (first < 0 && fo1[1] === 1'b1) first = e;
    end
    dchk("al_restart_after_reset_ch1", first, 17);

    // Randomized traffic.
    raw0 = 8'h00; raw1 = 8'hFF;
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(0, 23) == 0) raw0[c] = ~raw0[c];
        if ($urandom_range(0, 23) == 0) raw1[c] = ~raw1[c];
      end
      if ($urandom_range(0, 299) == 0) bypass = ~bypass;
      chatter_clr = ($urandom_range(0, 149) == 0);
      reset       = ($urandom_range(0, 1499) == 0);
      tick();
    end
    reset = 1'b0; chatter_clr = 1'b0;
    repeat (3) tick();
    dchk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
